// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// Adds flush/exception bubble injection and a saturating back-pressure counter.
module pipe_stage_skid #(
  parameter int          DATA_W     = 128,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [31:0]       m_pc;
  logic [DATA_W-1:0] m_data;
  logic [EXC_W-1:0]  m_exc;
  logic              m_bd;

  logic              s_valid;
  logic [31:0]       s_pc;
  logic [DATA_W-1:0] s_data;
  logic [EXC_W-1:0]  s_exc;
  logic              s_bd;

  logic in_fire;
  logic m_load;

  // in_ready comes straight from the skid flag, so it never combinationally depends on out_ready
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & in_ready;
  assign m_load   = ~m_valid | out_ready;

  assign out_valid = m_valid;
  assign out_pc    = m_pc;
  assign out_data  = m_data;
  assign out_exc   = m_exc;
  assign out_bd    = m_bd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_data  <= '0;
      m_exc   <= '0;
      m_bd    <= 1'b0;
      s_valid <= 1'b0;
      s_pc    <= '0;
      s_data  <= '0;
      s_exc   <= '0;
      s_bd    <= 1'b0;
    end else if (req || flush) begin
      // Bubble injection: req outranks flush, so it selects the handler PC
      m_valid <= 1'b0;
      m_pc    <= req ? HANDLER_PC : 32'h0;
      m_data  <= '0;
      m_exc   <= '0;
      m_bd    <= 1'b0;
      s_valid <= 1'b0;
      s_pc    <= '0;
      s_data  <= '0;
      s_exc   <= '0;
      s_bd    <= 1'b0;
    end else if (m_load) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_pc    <= s_pc;
        m_data  <= s_data;
        m_exc   <= s_exc;
        m_bd    <= s_bd;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        m_valid <= 1'b1;
        m_pc    <= in_pc;
        m_data  <= in_data;
        m_exc   <= in_exc;
        m_bd    <= in_bd;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_valid <= 1'b1;
      s_pc    <= in_pc;
      s_data  <= in_data;
      s_exc   <= in_exc;
      s_bd    <= in_bd;
    end
  end

  // Back-pressure counter keeps counting through req/flush; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (F/D, D/E, E/M, M/W).
- One generic stage register carries PC, an opaque payload bus, exception code and branch-delay flag between two pipeline stages.
- Adds a valid/ready handshake with a one-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Adds a separate flush path and an exception-request path that injects a bubble carrying the handler PC, plus a saturating back-pressure counter for CP0/perf readout.

Parameters:
DATA_W, 128, width of opaque payload (IR, ALU result, rt, HI/LO, etc. concatenated by instantiator)
EXC_W, 5, width of exception-code field
HANDLER_PC, 32'h0000_4180, PC value loaded into the bubble on exception request
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  exception request: kill stage contents, emit handler-PC bubble
flush  in  1  pipeline flush: kill stage contents, emit PC=0 bubble
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  32  upstream PC
in_data  in  DATA_W  upstream payload
in_exc  in  EXC_W  upstream exception code
in_bd  in  1  upstream branch-delay flag
out_valid  out  1  stage output holds a valid instruction
out_ready  in  1  downstream accepts this cycle
out_pc  out  32  stage PC
out_data  out  DATA_W  stage payload
out_exc  out  EXC_W  stage exception code
out_bd  out  1  stage branch-delay flag
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage:
  - Main register M drives all out_* directly (registered outputs).
  - Skid register S holds one overflow entry.
  - Each entry is {valid, pc, data, exc, bd}.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = ~S.valid, registered; it depends only on state, not on out_ready.
- Priority at each posedge: rst (async) > req > flush > normal.
- Reset (async, immediate): M and S cleared; out_valid=0, out_pc=0, out_data=0, out_exc=0, out_bd=0; in_ready=1; stall_cnt=0.
- req=1:
  - M <= {valid=0, pc=HANDLER_PC, data=0, exc=0, bd=0}; S cleared.
  - Any same-cycle in_fire is discarded.
  - in_ready=1 next cycle.
- flush=1 (req=0): same as req, but pc=0.
- Normal operation (M loaded when M empty or out_fire):
  - If S.valid: M<=S, S cleared. A same-cycle in_fire is impossible because in_ready=0.
  - Else if in_fire: M<=input.
  - Else: M.valid<=0 and the other M fields are held.
- Normal operation (M full and not out_fire):
  - If in_fire: S<=input.
  - M holds.
- Throughput and latency:
  - Throughput is 1 instruction/cycle with no bubbles while out_ready=1.
  - Latency in->out is 1 cycle.
  - Ordering is strictly FIFO: M before S.
- Full condition: M.valid & S.valid → in_ready=0. Upstream must hold its inputs while in_ready=0.
- stall_cnt:
  - Increments when out_valid & ~out_ready; holds at 2^CNT_W-1.
  - Cleared only by rst; unaffected by req/flush.
- Simultaneous cases:
  - req with out_fire: the downstream consumes the current M, then M becomes the bubble.
  - req and flush together: req wins, so pc=HANDLER_PC.
- Reset mid-operation: all in-flight entries lost; no partial output.

Test Plan:
1. Streaming: rst pulse, out_ready=1, drive in_valid=1 with pc 0x3000,0x3004,0x3008 on consecutive cycles → out_pc shows the same sequence one cycle later, out_valid=1 each cycle, in_ready stays 1, stall_cnt=0.
2. Back-pressure/skid: M holds 0x3000, then out_ready=0 while 0x3004 arrives → in_ready=0 next cycle, out_pc holds 0x3000, stall_cnt increments per cycle. Release out_ready → out_pc 0x3004 then 0x3008, with no loss or duplication.
3. Exception request with full skid: M=0x3000, S=0x3004, pulse req=1 → next cycle out_valid=0, out_pc=0x4180, out_exc=0, out_bd=0, in_ready=1, and 0x3004 is never emitted.
4. Flush vs req priority: flush=1 alone → out_pc=0, out_valid=0. Then flush=1 and req=1 together → out_pc=0x4180.
5. Async reset mid-stall: M and S both full, assert rst between clock edges → outputs go to 0 and in_ready to 1 immediately without a clock edge, and stall_cnt=0.
6. Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15. A later req leaves stall_cnt at 15.
